// File: rtl/axi_ts_measure.sv
// axi_ts_measure
//
// Device-side measurement executor. It accepts a start request from the
// trigger controller, acknowledges it, then waits a programmable number of
// cycles. It then captures a fixed number of samples from a free-running
// sample stream and forwards them with a last flag on the final sample. It
// then pulses done, bumps the completed-measurement counter and returns to
// idle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   measure_start             level start request (looked at only when idle)
//   measure_ready             one-cycle acknowledge of start
//   measure_idle              high while idle
//   measure_done              one-cycle completion pulse (same cycle as m_last)
//   ctrl_abort                abandon any measurement and return to idle
//   ctrl_delay, ctrl_length   delay cycles / samples per measurement (0 -> 1)
//   rtc_sec, rtc_nsec         real-time clock for the capture timestamp
//   s_valid, s_data           input sample stream (no backpressure)
//   m_valid, m_data, m_last   captured sample stream
//   stat_measure_count        completed measurements (wraps)
//   stat_ts_sec, stat_ts_nsec capture-start timestamp
//
// Build option: define AXI_TS_MEASURE_TIMESTAMP_EN to latch the RTC at each
// capture start. Without it the timestamp outputs are constant 0.
module axi_ts_measure #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  measure_start,
  output logic                  measure_ready,
  output logic                  measure_idle,
  output logic                  measure_done,
  input  logic                  ctrl_abort,
  input  logic [CNT_WIDTH-1:0]  ctrl_delay,
  input  logic [CNT_WIDTH-1:0]  ctrl_length,
  input  logic [31:0]           rtc_sec,
  input  logic [31:0]           rtc_nsec,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [31:0]           stat_measure_count,
  output logic [31:0]           stat_ts_sec,
  output logic [31:0]           stat_ts_nsec
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_READY, S_DELAY, S_CAPTURE, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_WIDTH-1:0]  delay_reg, length_reg;
  logic [CNT_WIDTH-1:0]  delay_cnt_reg, sample_cnt_reg;
  logic                  ready_reg, idle_reg, done_reg;
  logic                  ready_next, idle_next, done_next;
  logic                  m_valid_reg, m_last_reg;
  logic                  m_valid_next, m_last_next;
  logic [DATA_WIDTH-1:0] m_data_reg, m_data_next;
  logic [31:0]           count_reg, count_next;

  logic accept, last_accept, delay_end, start_take;

  assign accept      = (state_reg == S_CAPTURE) && s_valid;
  // length_reg is never 0, so length_reg-1 cannot underflow.
  assign last_accept = accept && (sample_cnt_reg == length_reg - CNT_ONE);
  // Comparing against delay-1 (not delay) keeps a max-value delay in range.
  assign delay_end   = (delay_cnt_reg == delay_reg - CNT_ONE);
  assign start_take  = (state_reg == S_IDLE) && (state_next == S_READY);

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_RST;
      ready_reg   <= 1'b0;
      idle_reg    <= 1'b0;
      done_reg    <= 1'b0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      ready_reg   <= ready_next;
      idle_reg    <= idle_next;
      done_reg    <= done_next;
      m_valid_reg <= m_valid_next;
      m_last_reg  <= m_last_next;
      m_data_reg  <= m_data_next;
      count_reg   <= count_next;
    end
  end

  // Next-state logic; abort overrides everything except the reset state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:     state_next = S_IDLE;
      S_IDLE:    if (measure_start) state_next = S_READY;
      S_READY:   state_next = (delay_reg != '0) ? S_DELAY : S_CAPTURE;
      S_DELAY:   if (delay_end) state_next = S_CAPTURE;
      S_CAPTURE: if (last_accept) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (ctrl_abort && (state_reg != S_RST)) state_next = S_IDLE;
  end

  // Output logic: status flags decode state_next so that after the register
  // they line up exactly with the state they describe.
  always_comb begin
    ready_next   = (state_next == S_READY);
    idle_next    = (state_next == S_IDLE);
    done_next    = (state_next == S_DONE);
    m_valid_next = accept && !ctrl_abort;
    m_last_next  = last_accept && !ctrl_abort;
    m_data_next  = accept ? s_data : m_data_reg;
    count_next   = count_reg;
    if ((state_next == S_DONE) && (state_reg != S_DONE)) count_next = count_reg + 32'd1;
  end

  // Configuration latch and phase counters. Each counter is held at zero
  // outside its own phase, so every measurement starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_reg      <= '0;
      length_reg     <= CNT_ONE;
      delay_cnt_reg  <= '0;
      sample_cnt_reg <= '0;
    end else begin
      if (start_take) begin
        delay_reg  <= ctrl_delay;
        length_reg <= (ctrl_length == '0) ? CNT_ONE : ctrl_length;
      end
      if (state_reg == S_DELAY) delay_cnt_reg <= delay_cnt_reg + CNT_ONE;
      else                      delay_cnt_reg <= '0;
      if (state_reg == S_CAPTURE) begin
        if (accept) sample_cnt_reg <= sample_cnt_reg + CNT_ONE;
      end else begin
        sample_cnt_reg <= '0;
      end
    end
  end

  assign measure_ready      = ready_reg;
  assign measure_idle       = idle_reg;
  assign measure_done       = done_reg;
  assign m_valid            = m_valid_reg;
  assign m_last             = m_last_reg;
  assign m_data             = m_data_reg;
  assign stat_measure_count = count_reg;

`ifdef AXI_TS_MEASURE_TIMESTAMP_EN
  logic [31:0] ts_sec_reg, ts_nsec_reg;

  // Abort forces state_next to idle, so an aborted run never reaches here.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_sec_reg  <= '0;
      ts_nsec_reg <= '0;
    end else if ((state_next == S_CAPTURE) && (state_reg != S_CAPTURE)) begin
      ts_sec_reg  <= rtc_sec;
      ts_nsec_reg <= rtc_nsec;
    end
  end

  assign stat_ts_sec  = ts_sec_reg;
  assign stat_ts_nsec = ts_nsec_reg;
`else
  logic unused_rtc;
  assign unused_rtc   = ^{rtc_sec, rtc_nsec};
  assign stat_ts_sec  = '0;
  assign stat_ts_nsec = '0;
`endif

endmodule

// File: tb/tb_axi_ts_measure.sv
// Testbench for axi_ts_measure: reset, exact timing sequence, a vector table
// of measurement shapes (including abort), held-start back-to-back runs,
// timestamp latch, and a randomized run checked against a cycle-timeline
// model built from the measurement rules.
`timescale 1ns/1ps
module tb_axi_ts_measure;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam int N  = 600;

`ifdef AXI_TS_MEASURE_TIMESTAMP_EN
  localparam logic [31:0] TS_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TS_MASK = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst, measure_start, ctrl_abort, s_valid;
  logic measure_ready, measure_idle, measure_done, m_valid, m_last;
  logic [CW-1:0] ctrl_delay, ctrl_length;
  logic [31:0] rtc_sec, rtc_nsec, stat_measure_count, stat_ts_sec, stat_ts_nsec;
  logic [DW-1:0] s_data, m_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_count = 32'd0;

  axi_ts_measure #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .measure_start(measure_start), .measure_ready(measure_ready),
    .measure_idle(measure_idle), .measure_done(measure_done),
    .ctrl_abort(ctrl_abort), .ctrl_delay(ctrl_delay), .ctrl_length(ctrl_length),
    .rtc_sec(rtc_sec), .rtc_nsec(rtc_nsec),
    .s_valid(s_valid), .s_data(s_data),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .stat_measure_count(stat_measure_count),
    .stat_ts_sec(stat_ts_sec), .stat_ts_nsec(stat_ts_nsec)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (!measure_idle && i < 50) begin
      tick();
      i++;
    end
    check("wait_idle", measure_idle, 1);
  endtask

  typedef struct {
    int delay;
    int length;
    int period;
    int abort_after;
    int exp_beats;
    bit exp_last;
    bit exp_done;
    int exp_inc;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input int idx, input vec_t v);
    int beats;
    bit saw_last, saw_done, fin;
    beats = 0; saw_last = 0; saw_done = 0; fin = 0;
    wait_idle();
    ctrl_abort = 0; s_valid = 0;
    ctrl_delay = v.delay; ctrl_length = v.length;
    measure_start = 1;
    tick();
    measure_start = 0;
    // New settings after the start must not affect this measurement.
    ctrl_delay = $urandom_range(5, 9);
    ctrl_length = $urandom_range(5, 9);
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      s_valid = (cyc % v.period) == 0;
      s_data = $urandom;
      if (m_valid) beats++;
      if (m_last) saw_last = 1;
      if (measure_done) begin
        saw_done = 1;
        check($sformatf("v%0d_done_with_last", idx), m_last, 1);
        fin = 1;
      end
      if (!fin && v.abort_after >= 0 && m_valid && beats == v.abort_after) begin
        ctrl_abort = 1;
        fin = 1;
      end
      tick();
      ctrl_abort = 0;
    end
    check($sformatf("v%0d_finished", idx), fin, 1);
    check($sformatf("v%0d_idle_after", idx), measure_idle, 1);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1;
      s_data = $urandom;
      if (m_valid) beats++;
      if (m_last) saw_last = 1;
      if (measure_done) saw_done = 1;
      tick();
    end
    s_valid = 0;
    exp_count += 32'(v.exp_inc);
    check($sformatf("v%0d_beats", idx), beats, v.exp_beats);
    check($sformatf("v%0d_last", idx), saw_last, v.exp_last);
    check($sformatf("v%0d_done", idx), saw_done, v.exp_done);
    check($sformatf("v%0d_count", idx), stat_measure_count, exp_count);
    $display("vec %0d: delay=%0d length=%0d beats=%0d last=%0d done=%0d count=%0d",
             idx, v.delay, v.length, beats, saw_last, saw_done, stat_measure_count);
  endtask

  // Randomized stimulus and expected timeline.
  bit          r_start [N];
  bit          r_sv    [N];
  logic [31:0] r_sd    [N];
  int          r_dly   [N];
  int          r_len   [N];
  logic [31:0] r_rs    [N];
  logic [31:0] r_rn    [N];
  bit          e_ready [N+2];
  bit          e_idle  [N+2];
  bit          e_valid [N+2];
  bit          e_last  [N+2];
  bit          e_done  [N+2];
  logic [31:0] e_data  [N+2];
  logic [31:0] e_cnt   [N+2];
  logic [31:0] e_tss   [N+2];
  logic [31:0] e_tsn   [N+2];
  bit          chg     [N+2];
  logic [31:0] chg_s   [N+2];
  logic [31:0] chg_n   [N+2];
  bit          inc     [N+2];

  task automatic random_phase();
    int t, k, got, lastk, len, meas;
    logic [31:0] cs, cn, c;
    for (int i = 0; i < N; i++) begin
      r_start[i] = (i < N - 60) && ($urandom_range(0, 3) == 0);
      r_sv[i]    = (i >= N - 60) || ($urandom_range(0, 9) < 6);
      r_sd[i]    = $urandom;
      r_dly[i]   = $urandom_range(0, 3);
      r_len[i]   = $urandom_range(0, 4);
    end
    for (int i = 0; i < N + 2; i++) begin
      e_ready[i] = 0; e_idle[i] = 1; e_valid[i] = 0; e_last[i] = 0; e_done[i] = 0;
      e_data[i] = 0; e_tss[i] = 0; e_tsn[i] = 0; chg[i] = 0; inc[i] = 0;
      chg_s[i] = 0; chg_n[i] = 0;
    end
    // Each start seen while idle: ready next cycle, capture from t+2+delay,
    // first L valid cycles are outputs one cycle later, done with the last.
    t = 0;
    while (t < N) begin
      if (!r_start[t]) begin
        t++;
      end else begin
        len = (r_len[t] == 0) ? 1 : r_len[t];
        k = t + 2 + r_dly[t];
        got = 0;
        lastk = k;
        while (got < len && k < N) begin
          if (r_sv[k]) begin
            got++;
            e_valid[k+1] = 1;
            e_data[k+1] = r_sd[k];
            lastk = k;
          end
          k++;
        end
        e_ready[t+1] = 1;
        for (int u = t + 1; u <= lastk + 1; u++) e_idle[u] = 0;
        e_last[lastk+1] = 1;
        e_done[lastk+1] = 1;
        inc[lastk+1] = 1;
        chg[t+1] = 1;
        chg_s[t+1] = $urandom;
        chg_n[t+1] = $urandom;
        e_tss[lastk+1] = chg_s[t+1];
        e_tsn[lastk+1] = chg_n[t+1];
        t = lastk + 2;
      end
    end
    cs = 0; cn = 0; c = exp_count;
    for (int i = 0; i < N; i++) begin
      if (chg[i]) begin cs = chg_s[i]; cn = chg_n[i]; end
      r_rs[i] = cs;
      r_rn[i] = cn;
      if (inc[i]) c = c + 32'd1;
      e_cnt[i] = c;
    end
    meas = 0;
    for (int i = 0; i < N; i++) begin
      measure_start = r_start[i];
      s_valid = r_sv[i];
      s_data = r_sd[i];
      ctrl_delay = r_dly[i];
      ctrl_length = r_len[i];
      rtc_sec = r_rs[i];
      rtc_nsec = r_rn[i];
      check($sformatf("rnd_ready_t%0d", i), measure_ready, e_ready[i]);
      check($sformatf("rnd_idle_t%0d", i), measure_idle, e_idle[i]);
      check($sformatf("rnd_valid_t%0d", i), m_valid, e_valid[i]);
      check($sformatf("rnd_last_t%0d", i), m_last, e_last[i]);
      check($sformatf("rnd_done_t%0d", i), measure_done, e_done[i]);
      check($sformatf("rnd_count_t%0d", i), stat_measure_count, e_cnt[i]);
      if (e_valid[i]) check($sformatf("rnd_data_t%0d", i), m_data, e_data[i]);
      if (e_done[i]) begin
        meas++;
        check($sformatf("rnd_ts_sec_t%0d", i), stat_ts_sec, e_tss[i] & TS_MASK);
        check($sformatf("rnd_ts_nsec_t%0d", i), stat_ts_nsec, e_tsn[i] & TS_MASK);
        $display("rnd measurement %0d done at cycle %0d count=%0d", meas, i, stat_measure_count);
      end
      tick();
    end
    measure_start = 0;
    exp_count = c;
  endtask

  initial begin
    int readies, beats, dones, prev_ready, ready_after;
    logic [5:0] last_mask;
    bit saw;

    rst = 1; measure_start = 0; ctrl_abort = 0; s_valid = 0; s_data = 0;
    ctrl_delay = 0; ctrl_length = 0; rtc_sec = 0; rtc_nsec = 0;

    vecs[0] = '{0, 0, 2, -1, 1, 1, 1, 1};
    vecs[1] = '{2, 8, 1,  3, 3, 0, 0, 0};
    vecs[2] = '{1, 5, 3, -1, 5, 1, 1, 1};
    vecs[3] = '{5, 1, 1, -1, 1, 1, 1, 1};

    // Reset state.
    repeat (3) tick();
    check("rst_ready", measure_ready, 0);
    check("rst_idle", measure_idle, 0);
    check("rst_done", measure_done, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_count", stat_measure_count, 0);
    check("rst_ts_sec", stat_ts_sec, 0);
    check("rst_ts_nsec", stat_ts_nsec, 0);
    rst = 0;
    check("rel_c1_idle", measure_idle, 0);
    tick();
    check("rel_c2_idle", measure_idle, 1);
    check("rel_c2_count", stat_measure_count, 0);
    $display("reset released, idle=%0d", measure_idle);

    // Exact timing: delay=3, length=4, s_valid always high, start at cycle 0.
    ctrl_delay = 3; ctrl_length = 4; s_valid = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      check($sformatf("tim_ready_c%0d", cyc), measure_ready, cyc == 1);
      check($sformatf("tim_idle_c%0d", cyc), measure_idle, (cyc == 0) || (cyc >= 10));
      check($sformatf("tim_valid_c%0d", cyc), m_valid, (cyc >= 6) && (cyc <= 9));
      check($sformatf("tim_last_c%0d", cyc), m_last, cyc == 9);
      check($sformatf("tim_done_c%0d", cyc), measure_done, cyc == 9);
      check($sformatf("tim_count_c%0d", cyc), stat_measure_count,
            exp_count + ((cyc >= 9) ? 32'd1 : 32'd0));
      if (cyc >= 6 && cyc <= 9)
        check($sformatf("tim_data_c%0d", cyc), m_data, 32'hA000_0000 + 32'(cyc - 1));
      measure_start = (cyc == 0);
      s_data = 32'hA000_0000 + 32'(cyc);
      if (cyc == 1) begin ctrl_delay = 7; ctrl_length = 1; end
      tick();
    end
    exp_count += 32'd1;
    s_valid = 0;
    $display("timing sequence complete, count=%0d", stat_measure_count);

    // Table of measurement shapes.
    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // measure_start held high: three back-to-back measurements.
    wait_idle();
    ctrl_delay = 1; ctrl_length = 2; s_valid = 1; measure_start = 1;
    readies = 0; beats = 0; dones = 0; prev_ready = -1; last_mask = 0;
    for (int cyc = 0; cyc < 100 && dones < 3; cyc++) begin
      s_data = $urandom;
      if (measure_ready) begin
        if (readies > 0) check($sformatf("held_gap_%0d", readies), cyc - prev_ready, 6);
        prev_ready = cyc;
        readies++;
      end
      if (m_valid) begin
        beats++;
        if (m_last && beats <= 6) last_mask[beats-1] = 1'b1;
      end
      if (measure_done) begin
        dones++;
        if (dones == 3) measure_start = 0;
      end
      tick();
    end
    exp_count += 32'd3;
    check("held_dones", dones, 3);
    check("held_readies", readies, 3);
    check("held_beats", beats, 6);
    check("held_last_mask", last_mask, 6'b101010);
    check("held_count", stat_measure_count, exp_count);
    ready_after = 0;
    for (int i = 0; i < 4; i++) begin
      if (measure_ready) ready_after++;
      tick();
    end
    check("held_no_more_ready", ready_after, 0);
    $display("held start: readies=%0d beats=%0d count=%0d", readies, beats, stat_measure_count);

    // Timestamp latch at capture start, held after done.
    wait_idle();
    rtc_sec = 32'h10; rtc_nsec = 32'h1234;
    ctrl_delay = 2; ctrl_length = 1; s_valid = 1; measure_start = 1;
    tick();
    measure_start = 0;
    saw = 0;
    for (int i = 0; i < 30 && !saw; i++) begin
      if (measure_done) saw = 1;
      tick();
    end
    check("ts_done_seen", saw, 1);
    exp_count += 32'd1;
    rtc_sec = 32'hDEAD; rtc_nsec = 32'hBEEF;
    repeat (3) tick();
    check("ts_sec_held", stat_ts_sec, 32'h10 & TS_MASK);
    check("ts_nsec_held", stat_ts_nsec, 32'h1234 & TS_MASK);
    $display("timestamp: sec=0x%0h nsec=0x%0h", stat_ts_sec, stat_ts_nsec);

    // Abort during delay: timestamp and count untouched.
    wait_idle();
    ctrl_delay = 20; ctrl_length = 2; measure_start = 1;
    tick();
    measure_start = 0;
    rtc_sec = 32'h99; rtc_nsec = 32'h98;
    repeat (5) tick();
    ctrl_abort = 1;
    tick();
    ctrl_abort = 0;
    check("abort_delay_idle", measure_idle, 1);
    check("abort_delay_ts_sec", stat_ts_sec, 32'h10 & TS_MASK);
    check("abort_delay_ts_nsec", stat_ts_nsec, 32'h1234 & TS_MASK);
    check("abort_delay_count", stat_measure_count, exp_count);
    $display("abort in delay: idle=%0d count=%0d", measure_idle, stat_measure_count);

    // Randomized run against the timeline model.
    s_valid = 0;
    wait_idle();
    tick();
    tick();
    random_phase();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_ts_measure.md
Name: axi_ts_measure

Overview:
- Measurement executor at the device end of the trigger subsystem's measure_start / measure_ready / measure_idle / measure_done handshake.
- On start it acknowledges, waits a programmable trigger delay, then captures a fixed number of samples from a free-running (no-backpressure) ADC sample stream and forwards them downstream framed with a last flag.
- It then pulses done, counts completed measurements and returns to idle.

Parameters:
- DATA_WIDTH, 32, width of s_data/m_data.
- CNT_WIDTH, 32, width of delay/length/sample counters and ctrl_delay/ctrl_length.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- measure_start  in  1  level request from trigger controller; sampled only in S_IDLE
- measure_ready  out  1  one-cycle acknowledge of start
- measure_idle  out  1  high while in S_IDLE
- measure_done  out  1  one-cycle pulse at measurement completion
- ctrl_abort  in  1  abort any measurement, return to idle
- ctrl_delay  in  CNT_WIDTH  cycles between ready and capture start
- ctrl_length  in  CNT_WIDTH  samples per measurement (0 treated as 1)
- rtc_sec  in  32  RTC seconds
- rtc_nsec  in  32  RTC nanoseconds
- s_valid  in  1  input sample strobe
- s_data  in  DATA_WIDTH  input sample
- m_valid  out  1  captured sample strobe
- m_data  out  DATA_WIDTH  captured sample
- m_last  out  1  marks final sample of a measurement
- stat_measure_count  out  32  completed measurements; wraps 0xFFFFFFFF->0
- stat_ts_sec  out  32  capture-start timestamp, seconds (see Optional Feature)
- stat_ts_nsec  out  32  capture-start timestamp, nanoseconds (see Optional Feature)

Behaviour:
- Reset
  - clk is the only clock; rst is synchronous and active-high.
  - state=S_RST. All outputs 0, including measure_idle. Counters 0.
  - S_RST -> S_IDLE unconditionally next cycle.
- States: S_RST, S_IDLE, S_READY, S_DELAY, S_CAPTURE, S_DONE.
- Status outputs are registered decodes of state_next, so each is high exactly while state equals its state:
  - measure_idle = S_IDLE
  - measure_ready = S_READY
  - measure_done = S_DONE
- Transitions
  - S_IDLE: measure_start=1 -> S_READY; ctrl_delay and ctrl_length latched on this edge (length 0 latched as 1).
  - S_READY -> S_DELAY if latched delay>0, else S_CAPTURE. Lasts exactly 1 cycle.
  - S_DELAY: delay counter increments each cycle; -> S_CAPTURE when count == delay-1, giving exactly delay cycles in S_DELAY.
  - S_CAPTURE: every cycle with s_valid=1 the sample is accepted and the sample counter increments; on the accept where count == length-1 -> S_DONE.
  - S_DONE -> S_IDLE after 1 cycle; stat_measure_count increments on entry to S_DONE.
- ctrl_abort
  - Highest priority: state_next=S_IDLE from any state except S_RST.
  - No measure_done, no m_last and no count increment for the aborted measurement.
  - m_valid is 0 from the cycle after abort is sampled.
- Data path
  - m_valid/m_data registered: a sample accepted at edge N appears on m_valid/m_data in cycle N+1.
  - m_last=1 only with the final accepted sample.
  - measure_done is high in the same cycle as m_last; the done pulse and last sample are coincident.
  - s_valid outside S_CAPTURE is ignored; no buffering, no backpressure.
- Start handling
  - measure_start held high after S_DONE starts a new measurement from S_IDLE. This is level semantics: back-to-back measurements need 1 idle cycle.
  - ctrl_delay/ctrl_length changes mid-measurement have no effect until the next start.
- Counters are CNT_WIDTH unsigned. Delay of 2^CNT_WIDTH-1 must work without overflow.

Optional Feature:
- Macro: AXI_TS_MEASURE_TIMESTAMP_EN.
- Defined:
  - stat_ts_sec/stat_ts_nsec latch rtc_sec/rtc_nsec on the cycle state enters S_CAPTURE.
  - They hold until the next capture start; reset value 0; unchanged on abort before capture.
- Not defined: stat_ts_sec/stat_ts_nsec tied to 0 and no latch registers are generated.

Test Plan:
- Reset release, measure_start=0 -> all outputs 0 during rst; measure_idle=1 from 2nd cycle after rst deassert; stat_measure_count=0.
- delay=3, length=4, s_valid always 1, start pulse at cycle 0:
  - measure_ready=1 at cycle 1 only.
  - Cycles 2-4 in S_DELAY.
  - m_valid=1 cycles 6-9 carrying samples of cycles 5-8.
  - m_last and measure_done=1 at cycle 9; measure_idle=1 at cycle 10; count=1.
- delay=0, length=0, s_valid every other cycle -> exactly 1 sample output with m_last=1; measure_done coincident; count increments by 1.
- length=8, ctrl_abort after 3 captured samples -> exactly 3 m_valid beats, no m_last, no measure_done, count unchanged, measure_idle=1 next cycle.
- measure_start held high for 3 measurements, length=2, delay=1 -> three ready pulses each separated by an idle cycle; count=3; 6 m_valid beats with m_last on beats 2, 4, 6.
- With AXI_TS_MEASURE_TIMESTAMP_EN, rtc_sec=0x10, rtc_nsec=0x1234 at capture entry -> stat_ts_sec=0x10, stat_ts_nsec=0x1234 held after done. Without the macro, both outputs read 0.
